// File: rtl/axi_instr_header_decoder.sv
// Parses the AXI-Stream command header, holds it for the batch FSM until done
// and meters write payload words. Optional 6th checksum word: HDR_CHECKSUM_EN.
module axi_instr_header_decoder #(
    parameter logic [7:0] SYNC_BYTE = 8'hA5,
    parameter int         CNT_W     = 21
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] s_axis_tdata,
    input  logic        s_axis_tvalid,
    output logic        s_axis_tready,
    input  logic        s_axis_tlast,
    input  logic        wr_path_ready,
    input  logic        batch_write_done,
    input  logic        batch_read_done,
    output logic [7:0]  Instruction_code,
    output logic [4:0]  wr_bram_start,
    output logic [4:0]  wr_bram_end,
    output logic [15:0] wr_addr_start,
    output logic [15:0] wr_addr_count,
    output logic [2:0]  rd_bram_start,
    output logic [2:0]  rd_bram_end,
    output logic [15:0] rd_addr_start,
    output logic [15:0] rd_addr_count,
    output logic        bram_wr_enable,
    output logic [31:0] payload_tdata,
    output logic        cmd_busy,
    output logic        cmd_done,
    output logic [1:0]  err_code,
    output logic        err_pulse,
    output logic        payload_len_err
);

`ifdef HDR_CHECKSUM_EN
    localparam int LAST_IDX = 5;
`else
    localparam int LAST_IDX = 4;
`endif

    typedef enum logic [1:0] {IDLE, HDR, ISSUE, ERR} state_t;

    state_t           state_q, state_d;
    logic [31:0]      sh_q [LAST_IDX];
    logic [2:0]       idx_q;
    logic [CNT_W-1:0] rem_q;
    logic [CNT_W-1:0] rem_after;
    logic [CNT_W-1:0] wr_total;
    logic             wr_seen_q, rd_seen_q;

    logic        hs, pay_hs, hdr_hs;
    logic [31:0] w1, w2, w3, w4;
    logic [7:0]  op;
    logic [5:0]  wr_span;
    logic        op_ok, wr_used, rd_used;
    logic        hdr_ok, cks_ok, retire_c;
    logic        issue, retire, err_set;
    logic [1:0]  err_val;
    logic        unused_bits;

    assign op = sh_q[0][7:0];
    assign w1 = sh_q[1];
    assign w2 = sh_q[2];
    assign w3 = sh_q[3];
`ifdef HDR_CHECKSUM_EN
    assign w4 = sh_q[4];
    assign cks_ok = s_axis_tdata == (sh_q[0] ^ w1 ^ w2 ^ w3 ^ w4);
`else
    assign w4 = s_axis_tdata;
    assign cks_ok = 1'b1;
`endif

    assign unused_bits = ^{sh_q[0][31:8], w1[31:21], w1[15:5],
                           w3[31:19], w3[15:3]};

    assign op_ok   = (op == 8'h01) || (op == 8'h02) || (op == 8'h03);
    assign wr_used = (op == 8'h01) || (op == 8'h03);
    assign rd_used = (op == 8'h02) || (op == 8'h03);
    assign hdr_ok  = op_ok
                   && (!wr_used || (w1[20:16] >= w1[4:0]))
                   && (!rd_used || (w3[18:16] >= w3[2:0]));

    // span is at most 32 and count at most 65535, so the product fits CNT_W
    assign wr_span  = {1'b0, w1[20:16]} - {1'b0, w1[4:0]} + 6'd1;
    assign wr_total = wr_used ? CNT_W'(wr_span) * CNT_W'(w2[31:16]) : '0;

    assign s_axis_tready = (state_q != ISSUE)
                         || (wr_path_ready && (rem_q != '0));
    assign hs     = s_axis_tvalid && s_axis_tready;
    assign pay_hs = hs && (state_q == ISSUE);
    assign hdr_hs = hs && ((state_q == IDLE) || (state_q == HDR));

    assign bram_wr_enable = pay_hs;
    assign payload_tdata  = s_axis_tdata;
    assign rem_after      = pay_hs ? rem_q - CNT_W'(1) : rem_q;

    assign retire_c =
        ((Instruction_code == 8'h01) && batch_write_done)
     || ((Instruction_code == 8'h02) && batch_read_done)
     || ((Instruction_code == 8'h03)
         && (wr_seen_q || batch_write_done)
         && (rd_seen_q || batch_read_done));

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        retire  = 1'b0;
        err_set = 1'b0;
        err_val = 2'b00;
        unique case (state_q)
            IDLE: if (hs) begin
                if (s_axis_tdata[31:24] != SYNC_BYTE) begin
                    err_set = 1'b1;
                    err_val = 2'b01;
                    state_d = s_axis_tlast ? IDLE : ERR;
                end else if (s_axis_tlast) begin
                    err_set = 1'b1;
                    err_val = 2'b10;
                end else begin
                    state_d = HDR;
                end
            end
            HDR: if (hs) begin
                if (idx_q == 3'(LAST_IDX)) begin
                    if (!cks_ok || !hdr_ok) begin
                        err_set = 1'b1;
                        err_val = cks_ok ? 2'b10 : 2'b11;
                        state_d = s_axis_tlast ? IDLE : ERR;
                    end else begin
                        issue   = 1'b1;
                        state_d = ISSUE;
                    end
                end else if (s_axis_tlast) begin
                    err_set = 1'b1;
                    err_val = 2'b10;
                    state_d = IDLE;
                end
            end
            ISSUE: if (retire_c) begin
                retire  = 1'b1;
                state_d = IDLE;
            end
            ERR: if (hs && s_axis_tlast) state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < LAST_IDX; i++) sh_q[i] <= '0;
            idx_q            <= '0;
            rem_q            <= '0;
            wr_seen_q        <= 1'b0;
            rd_seen_q        <= 1'b0;
            Instruction_code <= '0;
            wr_bram_start    <= '0;
            wr_bram_end      <= '0;
            wr_addr_start    <= '0;
            wr_addr_count    <= '0;
            rd_bram_start    <= '0;
            rd_bram_end      <= '0;
            rd_addr_start    <= '0;
            rd_addr_count    <= '0;
            cmd_busy         <= 1'b0;
            cmd_done         <= 1'b0;
            err_code         <= '0;
            err_pulse        <= 1'b0;
            payload_len_err  <= 1'b0;
        end else begin
            cmd_done        <= 1'b0;
            err_pulse       <= 1'b0;
            payload_len_err <= 1'b0;
            if (err_set) begin
                err_pulse <= 1'b1;
                err_code  <= err_val;
            end
            if (hdr_hs) begin
                for (int i = 0; i < LAST_IDX; i++)
                    if (idx_q == i[2:0]) sh_q[i] <= s_axis_tdata;
                idx_q <= idx_q + 3'd1;
            end
            if (state_d != HDR) idx_q <= '0;
            if (issue) begin
                Instruction_code <= op;
                wr_bram_start    <= w1[4:0];
                wr_bram_end      <= w1[20:16];
                wr_addr_start    <= w2[15:0];
                wr_addr_count    <= w2[31:16];
                rd_bram_start    <= w3[2:0];
                rd_bram_end      <= w3[18:16];
                rd_addr_start    <= w4[15:0];
                rd_addr_count    <= w4[31:16];
                rem_q            <= wr_total;
                cmd_busy         <= 1'b1;
                wr_seen_q        <= 1'b0;
                rd_seen_q        <= 1'b0;
            end
            if (state_q == ISSUE) begin
                if (batch_write_done) wr_seen_q <= 1'b1;
                if (batch_read_done)  rd_seen_q <= 1'b1;
            end
            if (pay_hs) begin
                rem_q <= rem_after;
                if (s_axis_tlast != (rem_q == CNT_W'(1)))
                    payload_len_err <= 1'b1;
            end
            // retiring with words still owed abandons them
            if (retire) begin
                Instruction_code <= '0;
                cmd_busy         <= 1'b0;
                cmd_done         <= 1'b1;
                rem_q            <= '0;
                if (rem_after != '0) payload_len_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_axi_instr_header_decoder.sv
// Bench for axi_instr_header_decoder: vector table, corner sequences and
// randomized commands checked against a span*count payload model.
module tb_axi_instr_header_decoder;

    logic        aclk = 1'b0;
    logic        aresetn = 1'b0;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tready;
    logic        s_axis_tlast;
    logic        wr_path_ready;
    logic        batch_write_done;
    logic        batch_read_done;
    logic [7:0]  Instruction_code;
    logic [4:0]  wr_bram_start, wr_bram_end;
    logic [15:0] wr_addr_start, wr_addr_count;
    logic [2:0]  rd_bram_start, rd_bram_end;
    logic [15:0] rd_addr_start, rd_addr_count;
    logic        bram_wr_enable;
    logic [31:0] payload_tdata;
    logic        cmd_busy, cmd_done;
    logic [1:0]  err_code;
    logic        err_pulse, payload_len_err;

    always #5 aclk = ~aclk;

    axi_instr_header_decoder dut (
        .aclk             (aclk),
        .aresetn          (aresetn),
        .s_axis_tdata     (s_axis_tdata),
        .s_axis_tvalid    (s_axis_tvalid),
        .s_axis_tready    (s_axis_tready),
        .s_axis_tlast     (s_axis_tlast),
        .wr_path_ready    (wr_path_ready),
        .batch_write_done (batch_write_done),
        .batch_read_done  (batch_read_done),
        .Instruction_code (Instruction_code),
        .wr_bram_start    (wr_bram_start),
        .wr_bram_end      (wr_bram_end),
        .wr_addr_start    (wr_addr_start),
        .wr_addr_count    (wr_addr_count),
        .rd_bram_start    (rd_bram_start),
        .rd_bram_end      (rd_bram_end),
        .rd_addr_start    (rd_addr_start),
        .rd_addr_count    (rd_addr_count),
        .bram_wr_enable   (bram_wr_enable),
        .payload_tdata    (payload_tdata),
        .cmd_busy         (cmd_busy),
        .cmd_done         (cmd_done),
        .err_code         (err_code),
        .err_pulse        (err_pulse),
        .payload_len_err  (payload_len_err)
    );

    typedef struct {
        logic [31:0] w0, w1, w2, w3, w4;
        bit          l4;
        logic [7:0]  code;
        logic [1:0]  err;
        int          nw;
    } vec_t;

    vec_t        tv [10];
    int          total = 0;
    int          bad = 0;
    int          n_done = 0;
    int          n_err = 0;
    int          n_lenerr = 0;
    logic [31:0] got_q [$];
    logic [31:0] sent_q [$];
    bit          rnd_rdy = 1'b0;

    always @(negedge aclk) begin
        if (aresetn) begin
            if (bram_wr_enable) got_q.push_back(payload_tdata);
            if (cmd_done) n_done++;
            if (err_pulse) n_err++;
            if (payload_len_err) n_lenerr++;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic put(input logic [31:0] d, input bit l);
        bit got;
        got = 1'b0;
        s_axis_tdata  = d;
        s_axis_tlast  = l;
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 200 && !got; k++) begin
            if (rnd_rdy) wr_path_ready = ($urandom_range(0, 3) != 0);
            @(negedge aclk);
            got = s_axis_tready;
            @(posedge aclk);
            #1;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        if (!got) begin
            total++;
            bad++;
            $display("FAIL put_timeout: got no tready want tready (%h)", d);
        end
    endtask

    task automatic send_hdr(input logic [31:0] h0, h1, h2, h3, h4,
                            input bit l4);
        put(h0, 1'b0);
        put(h1, 1'b0);
        put(h2, 1'b0);
        put(h3, 1'b0);
`ifdef HDR_CHECKSUM_EN
        put(h4, 1'b0);
        put(h0 ^ h1 ^ h2 ^ h3 ^ h4, l4);
`else
        put(h4, l4);
`endif
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    task automatic done_pulse(input bit w, input bit r);
        batch_write_done = w;
        batch_read_done  = r;
        cyc(1);
        batch_write_done = 1'b0;
        batch_read_done  = 1'b0;
    endtask

    task automatic retire(input string nm, input logic [7:0] code);
        done_pulse(code == 8'h01 || code == 8'h03,
                   code == 8'h02 || code == 8'h03);
        chk({nm, "_done"}, cmd_done, 1);
        chk({nm, "_code00"}, Instruction_code, 0);
        chk({nm, "_busy0"}, cmd_busy, 0);
        cyc(1);
        chk({nm, "_done1cyc"}, cmd_done, 0);
    endtask

    int          e0, d0, l0, mism, nexp;
    int          op, ws, we, cnt, rs, re;
    bit          drop;
    logic [31:0] r1, r2, r3, r4, d;

    initial begin
        s_axis_tdata     = '0;
        s_axis_tvalid    = 1'b0;
        s_axis_tlast     = 1'b0;
        wr_path_ready    = 1'b1;
        batch_write_done = 1'b0;
        batch_read_done  = 1'b0;

        tv[0] = '{32'hA5000001, 32'h00030001, 32'h00040010, 32'h0,
                  32'h0, 1'b0, 8'h01, 2'b00, 12};
        tv[1] = '{32'hA5000002, 32'h0, 32'h0, 32'h00050002,
                  32'h00080100, 1'b1, 8'h02, 2'b00, 0};
        tv[2] = '{32'hA5000003, 32'h00010001, 32'h00020000, 32'h0,
                  32'h00010000, 1'b0, 8'h03, 2'b00, 2};
        tv[3] = '{32'hA5000007, 32'h0, 32'h0, 32'h0,
                  32'h0, 1'b0, 8'h00, 2'b10, 0};
        tv[4] = '{32'hA5000001, 32'h00020004, 32'h00040000, 32'h0,
                  32'h0, 1'b0, 8'h00, 2'b10, 0};
        tv[5] = '{32'hA5000002, 32'h0, 32'h0, 32'h00010003,
                  32'h00010000, 1'b1, 8'h00, 2'b10, 0};
        tv[6] = '{32'hA5000002, 32'h00020004, 32'h0, 32'h0,
                  32'h00010000, 1'b1, 8'h02, 2'b00, 0};
        tv[7] = '{32'hA5000001, 32'h0, 32'h0, 32'h0,
                  32'h0, 1'b1, 8'h01, 2'b00, 0};
        tv[8] = '{32'hA5000001, 32'h001F001F, 32'h00010000, 32'h0,
                  32'h0, 1'b0, 8'h01, 2'b00, 1};
        tv[9] = '{32'hA5000003, 32'h0, 32'h00010000, 32'h00000007,
                  32'h0, 1'b0, 8'h00, 2'b10, 0};

        cyc(3);
        chk("rst_code", Instruction_code, 0);
        chk("rst_busy", cmd_busy, 0);
        chk("rst_done", cmd_done, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_wcnt", wr_addr_count, 0);
        aresetn = 1'b1;
        cyc(1);
        chk("idle_tready", s_axis_tready, 1);

        for (int i = 0; i < 10; i++) begin
            send_hdr(tv[i].w0, tv[i].w1, tv[i].w2, tv[i].w3, tv[i].w4,
                     tv[i].l4);
            chk($sformatf("v%0d_code", i), Instruction_code, tv[i].code);
            chk($sformatf("v%0d_busy", i), cmd_busy, tv[i].code != 0);
            if (tv[i].err != 2'b00) begin
                chk($sformatf("v%0d_errp", i), err_pulse, 1);
                chk($sformatf("v%0d_errc", i), err_code, tv[i].err);
                if (!tv[i].l4) put(32'hDEAD0000, 1'b1);
                cyc(1);
            end else begin
                chk($sformatf("v%0d_noerr", i), err_pulse, 0);
                got_q.delete();
                l0 = n_lenerr;
                for (int k = 0; k < tv[i].nw; k++)
                    put({i[7:0], 24'(k)}, k == tv[i].nw - 1);
                mism = 0;
                for (int k = 0; k < got_q.size(); k++)
                    if (got_q[k] != {i[7:0], 24'(k)}) mism++;
                chk($sformatf("v%0d_nwords", i), got_q.size(), tv[i].nw);
                chk($sformatf("v%0d_data", i), mism, 0);
                @(negedge aclk);
                chk($sformatf("v%0d_trdy0", i), s_axis_tready, 0);
                cyc(1);
                chk($sformatf("v%0d_lenok", i), n_lenerr - l0, 0);
                retire($sformatf("v%0d", i), tv[i].code);
            end
        end

        // read: tready held low, write_done ignored
        send_hdr(32'hA5000002, 0, 0, 32'h00050002, 32'h00100000, 1'b1);
        chk("rd_span", {rd_bram_end, rd_bram_start}, {3'd5, 3'd2});
        s_axis_tvalid = 1'b1;
        @(negedge aclk);
        chk("rd_trdy", s_axis_tready, 0);
        chk("rd_wren", bram_wr_enable, 0);
        cyc(1);
        s_axis_tvalid = 1'b0;
        d0 = n_done;
        done_pulse(1'b1, 1'b0);
        cyc(1);
        chk("rd_wdone_ign", Instruction_code, 2);
        chk("rd_wdone_cnt", n_done - d0, 0);
        retire("rd", 8'h02);

        // duplex with stall, write_done 5 cycles ahead of read_done
        send_hdr(32'hA5000003, 32'h0, 32'h00040000, 0, 0, 1'b0);
        got_q.delete();
        put(32'h11, 1'b0);
        put(32'h22, 1'b0);
        wr_path_ready = 1'b0;
        s_axis_tdata  = 32'h33;
        s_axis_tvalid = 1'b1;
        e0 = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge aclk);
            if (s_axis_tready || bram_wr_enable) e0++;
            cyc(1);
        end
        chk("dx_stall", e0, 0);
        wr_path_ready = 1'b1;
        put(32'h33, 1'b0);
        put(32'h44, 1'b1);
        chk("dx_n", got_q.size(), 4);
        if (got_q.size() == 4)
            chk("dx_data", {got_q[0][7:0], got_q[1][7:0],
                            got_q[2][7:0], got_q[3][7:0]}, 32'h11223344);
        d0 = n_done;
        done_pulse(1'b1, 1'b0);
        cyc(4);
        chk("dx_hold", Instruction_code, 3);
        chk("dx_nodone", n_done - d0, 0);
        done_pulse(1'b0, 1'b1);
        chk("dx_done", cmd_done, 1);
        chk("dx_code00", Instruction_code, 0);
        cyc(1);

        // bad sync, tlast on the 4th word, then a good command
        e0 = n_err;
        put(32'h5A000001, 1'b0);
        chk("bs_errp", err_pulse, 1);
        chk("bs_errc", err_code, 1);
        put(32'h1, 1'b0);
        put(32'h2, 1'b0);
        put(32'h3, 1'b1);
        cyc(1);
        chk("bs_one", n_err - e0, 1);
        chk("bs_code", Instruction_code, 0);
        send_hdr(32'hA5000002, 0, 0, 0, 0, 1'b1);
        chk("bs_next", Instruction_code, 2);
        retire("bs", 8'h02);

        // tlast on word 11 of 12
        send_hdr(tv[0].w0, tv[0].w1, tv[0].w2, 0, 0, 1'b0);
        for (int k = 0; k < 10; k++) put(k, 1'b0);
        put(32'hA, 1'b1);
        chk("le_pulse", payload_len_err, 1);
        put(32'hB, 1'b0);
        retire("le", 8'h01);

        // retire with payload outstanding
        send_hdr(tv[0].w0, tv[0].w1, tv[0].w2, 0, 0, 1'b0);
        for (int k = 0; k < 5; k++) put(k, 1'b0);
        done_pulse(1'b1, 1'b0);
        chk("er_done", cmd_done, 1);
        chk("er_lenerr", payload_len_err, 1);
        chk("er_trdy", s_axis_tready, 1);
        cyc(1);

        // asynchronous reset mid-payload
        send_hdr(tv[0].w0, tv[0].w1, tv[0].w2, 0, 0, 1'b0);
        for (int k = 0; k < 3; k++) put(k, 1'b0);
        d0 = n_done;
        #2 aresetn = 1'b0;
        #1;
        chk("ar_code", Instruction_code, 0);
        chk("ar_busy", cmd_busy, 0);
        chk("ar_wcnt", wr_addr_count, 0);
        chk("ar_wren", bram_wr_enable, 0);
        cyc(2);
        aresetn = 1'b1;
        cyc(3);
        chk("ar_nodone", n_done - d0, 0);
        send_hdr(32'hA5000002, 0, 0, 0, 0, 1'b1);
        chk("ar_next", Instruction_code, 2);
        retire("ar", 8'h02);

`ifdef HDR_CHECKSUM_EN
        put(32'hA5000002, 1'b0);
        put(32'h0, 1'b0);
        put(32'h0, 1'b0);
        put(32'h0, 1'b0);
        put(32'h0, 1'b0);
        put(32'h12345678, 1'b1);
        chk("ck_errp", err_pulse, 1);
        chk("ck_errc", err_code, 3);
        chk("ck_code", Instruction_code, 0);
        cyc(1);
`endif

        // randomized commands against the span*count model
        for (int it = 0; it < 25; it++) begin
            op  = $urandom_range(1, 3);
            ws  = $urandom_range(0, 28);
            we  = ws + $urandom_range(0, 3);
            cnt = $urandom_range(0, 5);
            rs  = $urandom_range(0, 5);
            re  = rs + $urandom_range(0, 2);
            nexp = (op != 2) ? (we - ws + 1) * cnt : 0;
            drop = (nexp != 0) && ($urandom_range(0, 4) == 0);
            r1 = {11'd0, 5'(we), 11'd0, 5'(ws)};
            r2 = {16'(cnt), 16'($urandom)};
            r3 = {13'd0, 3'(re), 13'd0, 3'(rs)};
            r4 = $urandom;
            rnd_rdy = 1'b1;
            send_hdr({24'hA50000, 8'(op)}, r1, r2, r3, r4, nexp == 0);
            chk($sformatf("r%0d_code", it), Instruction_code, op);
            chk($sformatf("r%0d_wcnt", it), wr_addr_count, cnt);
            chk($sformatf("r%0d_rst", it), rd_addr_start, r4[15:0]);
            got_q.delete();
            sent_q.delete();
            l0 = n_lenerr;
            for (int k = 0; k < nexp; k++) begin
                d = $urandom;
                sent_q.push_back(d);
                put(d, (k == nexp - 1) && !drop);
            end
            rnd_rdy = 1'b0;
            wr_path_ready = 1'b1;
            cyc(1);
            mism = (got_q.size() != sent_q.size()) ? 1 : 0;
            for (int k = 0; k < got_q.size() && k < sent_q.size(); k++)
                if (got_q[k] != sent_q[k]) mism++;
            chk($sformatf("r%0d_data", it), mism, 0);
            chk($sformatf("r%0d_len", it), n_lenerr - l0, drop ? 1 : 0);
            if (op == 3 && it[0]) begin
                done_pulse(1'b1, 1'b0);
                cyc(2);
                chk($sformatf("r%0d_hold", it), cmd_busy, 1);
            end
            retire($sformatf("r%0d", it), 8'(op));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
